led_matrix_scan_ctrl: RTL

Row-scan scheduler for the 8x8 RGB LED matrix. A pattern source writes frames through a valid/ready port into a double buffer. The block time-multiplexes the displayed frame one row at a time onto `led_row` (active-high) and `led_col_r/g/b` (active-low). Frame swaps happen only at frame boundaries, and a blanking gap is inserted between rows to suppress ghosting.

---
 rtl/led_matrix_pkg.sv | 24 ++
 rtl/led_frame_buf.sv | 65 ++++++
 rtl/led_matrix_scan_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 RGB LED matrix scan controller.
package led_matrix_pkg;

  localparam int ROWS          = 8;
  localparam int COLS          = 8;
  localparam int ROW_W         = $clog2(ROWS);
  localparam int BRIGHT_STEPS  = 8;

  localparam logic [COLS-1:0] COL_OFF = 8'hFF;
  localparam logic [ROWS-1:0] ROW_OFF = 8'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // One matrix row of pixel-on bits, bit i = column i, 1 = lit.
  typedef struct packed {
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic [COLS-1:0] b;
  } rgb_row_t;

endpackage

// File: rtl/led_frame_buf.sv
// Double frame buffer: writes land in the back copy, the front copy feeds the
// scan, and a committed frame becomes the front on the next swap strobe.
module led_frame_buf
  import led_matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  rgb_row_t         wr_data,
  input  logic             wr_last,
  input  logic             swap_stb,
  input  logic [ROW_W-1:0] rd_row,
  output rgb_row_t         rd_data,
  output logic             swap_pending
);

  rgb_row_t mem_q [2][ROWS];
  rgb_row_t mem_d [2][ROWS];
  logic     front_sel_q, front_sel_d;
  logic     pending_q, pending_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    mem_d       = mem_q;
    front_sel_d = front_sel_q;
    pending_d   = pending_q;

    if (swap_stb && pending_q) begin
      front_sel_d = ~front_sel_q;
      pending_d   = 1'b0;
    end

    // A write on the swap cycle still targets the pre-swap back copy.
    if (wr_en) begin
      mem_d[~front_sel_q][wr_row] = wr_data;
      if (wr_last) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the buffers are explicitly cleared because a reset must
      // discard any displayed or partial frame and come back dark.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[b][r] <= '0;
        end
      end
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      mem_q       <= mem_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
    end
  end

  assign rd_data      = mem_q[front_sel_q][rd_row];
  assign swap_pending = pending_q;

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan scheduler for the 8x8 RGB LED matrix with blanking between rows.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds a 3-bit per-row duty control.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int ROW_DWELL    = 6250,
  parameter int BLANK_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       wr_last,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [2:0] brightness,
`endif
  output logic [7:0] led_row,
  output logic [7:0] led_col_r,
  output logic [7:0] led_col_g,
  output logic [7:0] led_col_b,
  output logic       frame_sync
);

  localparam int CNT_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;

  logic [ROWS-1:0]  led_row_q, led_row_d;
  rgb_row_t         col_q, col_d;
  logic             frame_sync_q, frame_sync_d;

  rgb_row_t         front_row;
  logic             swap_pending;
  logic             wr_accept;
  logic             data_on;

  assign wr_ready  = !swap_pending;
  assign wr_accept = wr_valid && wr_ready;

  led_frame_buf u_frame_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_accept),
    .wr_row       (wr_row),
    .wr_data      ({wr_r, wr_g, wr_b}),
    .wr_last      (wr_last),
    .swap_stb     (frame_sync_q),
    .rd_row       (row_d),
    .rd_data      (front_row),
    .swap_pending (swap_pending)
  );

  // The idle reset cycle re-enters BLANK row 0 so the first active cycle is a
  // full-length frame boundary.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q + CNT_W'(1);
    started_d = 1'b1;

    if (!started_q) begin
      state_d = ST_BLANK;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_W'(ROW_DWELL - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            row_d   = row_q + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [2:0] bright_q, bright_d;

  always_comb begin
    bright_d = bright_q;
    if (state_q == ST_BLANK && state_d == ST_DRIVE) bright_d = brightness;
  end

  always_ff @(posedge clk) begin
    if (!rst) bright_q <= '0;
    else      bright_q <= bright_d;
  end

  assign data_on = int'(cnt_d) < (int'(bright_d) + 1) * (ROW_DWELL / BRIGHT_STEPS);
`else
  assign data_on = 1'b1;
`endif

  // Outputs are computed from the next scan position so they register on the
  // same edge that enters it.
  always_comb begin
    led_row_d    = ROW_OFF;
    col_d        = {COL_OFF, COL_OFF, COL_OFF};
    frame_sync_d = (state_d == ST_BLANK) && (row_d == '0) && (cnt_d == '0);

    if (state_d == ST_DRIVE) begin
      led_row_d = ROWS'(1) << row_d;
      if (data_on) col_d = ~front_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      row_q        <= '0;
      cnt_q        <= '0;
      started_q    <= 1'b0;
      led_row_q    <= ROW_OFF;
      col_q        <= {COL_OFF, COL_OFF, COL_OFF};
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      started_q    <= started_d;
      led_row_q    <= led_row_d;
      col_q        <= col_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign led_row    = led_row_q;
  assign led_col_r  = col_q.r;
  assign led_col_g  = col_q.g;
  assign led_col_b  = col_q.b;
  assign frame_sync = frame_sync_q;

endmodule
